fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Program-counter and IF/ID stage. Sits directly upstream of the instruction ROM: drives its address and enable.
//  Registers the returned instruction, with its PC and PC+4, into the IF/ID pipeline register for decode.
//  Handles hazard stall, instruction-miss stall, flush, branch/jump redirect and exception vectoring.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  EXC_VECTOR  32'h0000_0080  PC loaded on exception redirect
//  NOP_INSTR   32'h0000_0000  instruction word placed in IF/ID on bubble/flush
// PORTS
//  Clk            in   1   clock, all state on rising edge
//  Rst_n          in   1   asynchronous, active-low reset
//  Stall          in   1   hazard unit: hold PC and IF/ID contents
//  Flush          in   1   squash IF/ID (insert bubble)
//  Exc            in   1   exception redirect to EXC_VECTOR
//  Branch_Taken   in   1   branch resolved taken
//  Branch_Target  in   32  branch target address
//  Jump           in   1   unconditional jump
//  Jump_Target    in   32  jump target address
//  Imem_Addr      out  32  instruction memory address (= PC)
//  Imem_En        out  1   instruction memory enable
//  Imem_Data      in   32  instruction word, combinational read of Imem_Addr
//  Imiss          in   1   instruction not available this cycle
//  IfId_Instr     out  32  registered instruction
//  IfId_PC        out  32  registered PC of IfId_Instr
//  IfId_PC4       out  32  registered PC+4
//  IfId_Valid     out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (Rst_n=0, async): PC=RESET_PC, IfId_Instr=NOP_INSTR, IfId_PC=IfId_PC4=0, IfId_Valid=0. Imem_En=0 while in reset.
//  Imem_Addr=PC combinationally. Imem_En = Rst_n & ~Stall.
//  Fetch latency: instruction at PC appears on IfId_* one edge after PC is presented.
//  Next-PC priority (highest first):
//    Exc -> EXC_VECTOR; Branch_Taken -> Branch_Target; Jump -> Jump_Target;
//    Stall or Imiss -> hold PC; else PC+4.
//  Redirect (Exc/Branch_Taken/Jump) overrides Stall and Imiss.
//  Target bits [1:0] forced to 0 on load; no alignment fault is raised.
//  PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
//  IF/ID update priority on each edge:
//    redirect or Flush -> bubble; Stall (no redirect/Flush) -> hold all IF/ID fields;
//    Imiss -> bubble; else load {Imem_Data, PC, PC+4}, Valid=1.
//    Bubble = Instr NOP_INSTR, Valid 0; PC fields don't-care, implement as hold.
//  Simultaneous Stall+Flush: Flush wins for IF/ID; PC held unless a redirect is also present.
//  Imiss with no Stall: PC held and a bubble issued every cycle until Imiss drops; the same PC is then refetched.
//  Reset asserted mid-stall or mid-miss: immediate return to reset state; no pending redirect is remembered.
//  No combinational path from Imem_Data to any output.
// STRUCTURE
//  Shared pipeline package: ADDR_W=32, INSTR_W=32, NOP_INSTR, RESET_PC, EXC_VECTOR, and the IF/ID record field widths.
//  One sub-module, if_id_reg: holds the IF/ID fields, with load/hold/bubble control and async active-low reset.
//  Next-PC selection and the PC register stay in fetch_stage.
// TESTING
//  1. Reset release, no stall, ROM returns 0x11,0x22,0x33: PC 0,4,8,C. IfId_PC=0 with Instr 0x11 one edge after reset release, Valid=1.
//  2. Stall held 3 cycles at PC=8: PC stays 8, Imem_En=0, IfId fields unchanged. Release: PC=C next edge.
//  3. Branch_Taken with Branch_Target=0x102 while Stall=1: PC=0x100 next edge, IfId_Valid=0. Instr at 0x100 appears the following edge.
//  4. Exc and Jump asserted together (Jump_Target=0x40): PC=0x80, bubble in IF/ID.
//  5. Imiss high 2 cycles at PC=0x10: two bubbles, PC held at 0x10. After Imiss drops, IfId_PC=0x10, Valid=1.
//  6. PC=0xFFFF_FFFC, free running: next PC=0; IfId_PC4=0. Assert Rst_n=0 mid-Imiss: outputs reset asynchronously, before the next Clk edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, reset/exception
// addresses, the bubble instruction and the IF/ID record layout.
package fetch_stage_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  EXC_VECTOR = 32'h0000_0080;

    // IF/ID pipeline record handed to decode
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
        logic               valid;
    } ifid_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped silently
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched record, hold it, or turn it into a
// bubble (NOP, invalid) while keeping the PC fields as they were.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
    input  logic  Clk,
    input  logic  Rst_n,
    input  logic  load_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;

    // Bubble beats load; neither means hold
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ifid_q.instr <= NOP;
            ifid_q.pc    <= '0;
            ifid_q.pc4   <= '0;
            ifid_q.valid <= 1'b0;
        end else if (bubble_i) begin
            ifid_q.instr <= NOP;
            ifid_q.valid <= 1'b0;
        end else if (load_i) begin
            ifid_q <= d_i;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Program counter and IF/ID stage. Drives the instruction ROM address/enable,
// picks the next PC (exception > branch > jump > hold > +4) and steers the
// IF/ID register between load, hold and bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = fetch_stage_pkg::EXC_VECTOR,
    parameter logic [31:0] NOP_INSTR  = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Exc,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    output logic [31:0] Imem_Addr,
    output logic        Imem_En,
    input  logic [31:0] Imem_Data,
    input  logic        Imiss,
    output logic [31:0] IfId_Instr,
    output logic [31:0] IfId_PC,
    output logic [31:0] IfId_PC4,
    output logic        IfId_Valid
);

    import fetch_stage_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic              ifid_load, ifid_bubble;
    ifid_t             ifid_d, ifid_q;

    assign redirect = Exc | Branch_Taken | Jump;
    assign pc_plus4 = pc_q + 32'd4;   // wraps naturally at 2^32

    // Next-PC select: any redirect overrides stall and miss
    always_comb begin
        pc_d = pc_plus4;
        if (Exc)
            pc_d = word_align(EXC_VECTOR);
        else if (Branch_Taken)
            pc_d = word_align(Branch_Target);
        else if (Jump)
            pc_d = word_align(Jump_Target);
        else if (Stall || Imiss)
            pc_d = pc_q;
    end

    // PC register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    // A redirect or flush squashes whatever was fetched; a stall freezes IF/ID;
    // a miss with no stall yields a bubble and the same PC is fetched again.
    assign ifid_bubble = redirect | Flush | (~Stall & Imiss);
    assign ifid_load   = ~redirect & ~Flush & ~Stall & ~Imiss;

    assign ifid_d.instr = Imem_Data;
    assign ifid_d.pc    = pc_q;
    assign ifid_d.pc4   = pc_plus4;
    assign ifid_d.valid = 1'b1;

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id_reg (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign Imem_Addr  = pc_q;
    assign Imem_En    = Rst_n & ~Stall;
    assign IfId_Instr = ifid_q.instr;
    assign IfId_PC    = ifid_q.pc;
    assign IfId_PC4   = ifid_q.pc4;
    assign IfId_Valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Each vector carries the inputs for one
// cycle plus the hand-computed pre-edge address/enable and post-edge IF/ID
// contents; a monitor pops those and compares against the DUT.
module tb_fetch_stage;

    logic        Clk;
    logic        Rst_n;
    logic        Stall, Flush, Exc, Branch_Taken, Jump, Imiss;
    logic [31:0] Branch_Target, Jump_Target;
    logic [31:0] Imem_Addr, Imem_Data;
    logic        Imem_En;
    logic [31:0] IfId_Instr, IfId_PC, IfId_PC4;
    logic        IfId_Valid;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Stall         (Stall),
        .Flush         (Flush),
        .Exc           (Exc),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Jump          (Jump),
        .Jump_Target   (Jump_Target),
        .Imem_Addr     (Imem_Addr),
        .Imem_En       (Imem_En),
        .Imem_Data     (Imem_Data),
        .Imiss         (Imiss),
        .IfId_Instr    (IfId_Instr),
        .IfId_PC       (IfId_PC),
        .IfId_PC4      (IfId_PC4),
        .IfId_Valid    (IfId_Valid)
    );

    // Clock starts high so the first falling edge precedes the first rising edge
    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    // ROM model: 0x11/0x22/0x33 at 0/4/8, otherwise address xor a fixed tag
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h11;
        if (a == 32'h4) return 32'h22;
        if (a == 32'h8) return 32'h33;
        return a ^ 32'hA5A5_0000;
    endfunction

    always_comb Imem_Data = rom(Imem_Addr);

    typedef struct {
        logic        st, fl, ex, bt;
        logic [31:0] btg;
        logic        jm;
        logic [31:0] jtg;
        logic        im;
        logic [31:0] addr;
        logic        en;
        logic        vld;
        logic [31:0] ins, pc, pc4;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic        vld;
        logic [31:0] ins, pc, pc4;
    } exp_t;

    exp_t exp_q[$];

    function automatic vec_t mk(input logic st, fl, ex, bt, input logic [31:0] btg,
                                input logic jm, input logic [31:0] jtg, input logic im,
                                input logic [31:0] addr, input logic en, input logic vld,
                                input logic [31:0] ins, pc, pc4);
        vec_t v;
        v.st = st; v.fl = fl; v.ex = ex; v.bt = bt; v.btg = btg;
        v.jm = jm; v.jtg = jtg; v.im = im;
        v.addr = addr; v.en = en; v.vld = vld; v.ins = ins; v.pc = pc; v.pc4 = pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        Stall = 0; Flush = 0; Exc = 0; Branch_Taken = 0; Jump = 0; Imiss = 0;
        Branch_Target = '0; Jump_Target = '0;
    endtask

    // Monitor: pre-edge ROM interface, then post-edge IF/ID record
    initial begin
        logic [31:0] s_addr;
        logic        s_en;
        exp_t        e;
        forever begin
            @(negedge Clk);
            #3;
            if (exp_q.size() == 0) continue;
            s_addr = Imem_Addr;
            s_en   = Imem_En;
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            chk("imem_addr", s_addr, e.addr);
            chk("imem_en",   {31'b0, s_en}, {31'b0, e.en});
            chk("ifid_valid", {31'b0, IfId_Valid}, {31'b0, e.vld});
            chk("ifid_instr", IfId_Instr, e.ins);
            chk("ifid_pc",    IfId_PC, e.pc);
            chk("ifid_pc4",   IfId_PC4, e.pc4);
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        exp_t e;
        logic [31:0] T;
        T = 32'hA5A5_0000;

        // Reset plus normal fetch from 0
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h0,   1, 1, 32'h11, 32'h0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h4,   1, 1, 32'h22, 32'h4, 32'h8));
        // Stall three cycles at PC=8
        vecs.push_back(mk(1,0,0,0,0, 0,0, 0, 32'h8,   0, 1, 32'h22, 32'h4, 32'h8));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 0, 32'h8,   0, 1, 32'h22, 32'h4, 32'h8));
        vecs.push_back(mk(1,0,0,0,0, 0,0, 0, 32'h8,   0, 1, 32'h22, 32'h4, 32'h8));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h8,   1, 1, 32'h33, 32'h8, 32'hC));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'hC,   1, 1, T|32'hC, 32'hC, 32'h10));
        // Branch to misaligned 0x102 under stall
        vecs.push_back(mk(1,0,0,1,32'h102, 0,0, 0, 32'h10, 0, 0, 32'h0, 32'hC, 32'h10));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h100, 1, 1, T|32'h100, 32'h100, 32'h104));
        // Exception beats jump
        vecs.push_back(mk(0,0,1,0,0, 1,32'h40, 0, 32'h104, 1, 0, 32'h0, 32'h100, 32'h104));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h80,  1, 1, T|32'h80, 32'h80, 32'h84));
        // Jump to 0x10 then two miss cycles
        vecs.push_back(mk(0,0,0,0,0, 1,32'h10, 0, 32'h84, 1, 0, 32'h0, 32'h80, 32'h84));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 1, 32'h10,  1, 0, 32'h0, 32'h80, 32'h84));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 1, 32'h10,  1, 0, 32'h0, 32'h80, 32'h84));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h10,  1, 1, T|32'h10, 32'h10, 32'h14));
        // Stall+Flush: bubble, PC held
        vecs.push_back(mk(1,1,0,0,0, 0,0, 0, 32'h14,  0, 0, 32'h0, 32'h10, 32'h14));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h14,  1, 1, T|32'h14, 32'h14, 32'h18));
        // Jump near top of space, then wrap
        vecs.push_back(mk(0,0,0,0,0, 1,32'hFFFF_FFFE, 0, 32'h18, 1, 0, 32'h0, 32'h14, 32'h18));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'hFFFF_FFFC, 1, 1, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 0, 32'h0,   1, 1, 32'h11, 32'h0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0, 0,0, 1, 32'h4,   1, 0, 32'h0, 32'h0, 32'h4));

        drive_idle();
        Rst_n = 1'b0;
        #2;
        chk("rst_addr",  Imem_Addr, 32'h0);
        chk("rst_en",    {31'b0, Imem_En}, 32'h0);
        chk("rst_valid", {31'b0, IfId_Valid}, 32'h0);
        chk("rst_instr", IfId_Instr, 32'h0);
        chk("rst_pc",    IfId_PC, 32'h0);
        chk("rst_pc4",   IfId_PC4, 32'h0);
        #1 Rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge Clk);
            #1;
            Stall = vecs[i].st; Flush = vecs[i].fl; Exc = vecs[i].ex;
            Branch_Taken = vecs[i].bt; Branch_Target = vecs[i].btg;
            Jump = vecs[i].jm; Jump_Target = vecs[i].jtg; Imiss = vecs[i].im;
            e.addr = vecs[i].addr; e.en = vecs[i].en; e.vld = vecs[i].vld;
            e.ins = vecs[i].ins; e.pc = vecs[i].pc; e.pc4 = vecs[i].pc4;
            exp_q.push_back(e);
        end
        @(posedge Clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        // Reset mid-miss: PC sits at 4, IfId_PC4=4; reset must act before the next edge
        @(negedge Clk);
        #1;
        drive_idle();
        Imiss = 1'b1;
        #2 Rst_n = 1'b0;
        #1;
        chk("async_rst_addr",  Imem_Addr, 32'h0);
        chk("async_rst_en",    {31'b0, Imem_En}, 32'h0);
        chk("async_rst_valid", {31'b0, IfId_Valid}, 32'h0);
        chk("async_rst_pc4",   IfId_PC4, 32'h0);
        chk("async_rst_instr", IfId_Instr, 32'h0);

        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
